mbc1_ctrl: RTL

MBC1_CTRL -- requirements
Module: mbc1_ctrl

---
 rtl/mbc1_ctrl_pkg.sv | 28 ++
 rtl/mbc1_ctrl_if.sv | 25 ++
 rtl/mbc1_ctrl_wr_strobe_det.sv | 77 +++++++
 rtl/mbc1_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/mbc1_ctrl_pkg.sv
// Shared constants for the MBC1 cartridge mapper.
// Covers write-FSM states, read-source codes, address regions and the RAM-enable key.
package mbc1_ctrl_pkg;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t ST_IDLE   = 2'd0;
  localparam wr_state_t ST_LOW    = 2'd1;
  localparam wr_state_t ST_COMMIT = 2'd2;

  localparam logic [1:0] RD_ROM  = 2'd0;
  localparam logic [1:0] RD_RAM  = 2'd1;
  localparam logic [1:0] RD_OPEN = 2'd2;

  // 8 KiB regions selected by A[15:13]
  localparam logic [2:0] REGION_RAM_EN  = 3'b000;
  localparam logic [2:0] REGION_BANK_LO = 3'b001;
  localparam logic [2:0] REGION_BANK_HI = 3'b010;
  localparam logic [2:0] REGION_MODE    = 3'b011;
  localparam logic [2:0] REGION_EXT_RAM = 3'b101;

  localparam logic [3:0] RAM_EN_KEY = 4'hA;

  // Bank 0 is not selectable in the switchable window; it aliases to bank 1.
  function automatic logic [4:0] fix_bank_lo(input logic [4:0] d);
    return (d == 5'd0) ? 5'd1 : d;
  endfunction

endpackage

// File: rtl/mbc1_ctrl_if.sv
// Cartridge-side bus between the CPU bus synchronizer (master) and the mapper (slave).
interface mbc1_ctrl_if #(
  parameter int ROM_ADDR_W = 17,
  parameter int RAM_ADDR_W = 15
);
  logic [15:0]           bus_A_s;
  logic [7:0]            bus_D_s;
  logic                  bus_nWR_s;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  ram_we;
  logic [7:0]            ram_wd;
  logic [1:0]            rd_sel;
  logic [4:0]            rom_bank;

  modport master (
    output bus_A_s, bus_D_s, bus_nWR_s,
    input  rom_addr, ram_addr, ram_we, ram_wd, rd_sel, rom_bank
  );

  modport slave (
    input  bus_A_s, bus_D_s, bus_nWR_s,
    output rom_addr, ram_addr, ram_we, ram_wd, rd_sel, rom_bank
  );
endinterface

// File: rtl/mbc1_ctrl_wr_strobe_det.sv
// Glitch-filtered write detector: nWR must stay low MIN_WR_LOW clocks inside LOW,
// then its rising edge yields a one-cycle commit with the address/data latched at that edge.
module wr_strobe_det
  import mbc1_ctrl_pkg::*;
#(
  parameter int MIN_WR_LOW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        nwr,
  input  logic [15:0] addr_in,
  input  logic [7:0]  data_in,
  output logic        commit,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out
);

  localparam int CNT_W = (MIN_WR_LOW < 1) ? 1 : $clog2(MIN_WR_LOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_WR_LOW);

  wr_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (!nwr && enable) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      end
      ST_LOW: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!nwr) begin
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q >= CNT_MAX) begin
          state_d = ST_COMMIT;
          addr_d  = addr_in;
          data_d  = data_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign commit   = (state_q == ST_COMMIT);
  assign addr_out = addr_q;
  assign data_out = data_q;

endmodule

// File: rtl/mbc1_ctrl.sv
// MBC1 mapper: bank/mode/RAM-enable registers written through the glitch-filtered
// detector, plus combinational ROM/RAM address translation and read-source select.
module mbc1_ctrl
  import mbc1_ctrl_pkg::*;
#(
  parameter int ROM_ADDR_W = 17,
  parameter int RAM_ADDR_W = 15,
  parameter int MIN_WR_LOW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  mbc1_ctrl_if.slave   bus
);

  logic        commit;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        do_commit;
  logic [2:0]  wr_region;

  logic       ram_en_q, ram_en_d;
  logic [4:0] bank_lo_q, bank_lo_d;
  logic [1:0] bank_hi_q, bank_hi_d;
  logic       mode_q, mode_d;

  wr_strobe_det #(.MIN_WR_LOW(MIN_WR_LOW)) u_wr_det (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .nwr      (bus.bus_nWR_s),
    .addr_in  (bus.bus_A_s),
    .data_in  (bus.bus_D_s),
    .commit   (commit),
    .addr_out (wr_addr),
    .data_out (wr_data)
  );

  assign do_commit = commit && enable;
  assign wr_region = wr_addr[15:13];

  always_comb begin
    ram_en_d  = ram_en_q;
    bank_lo_d = bank_lo_q;
    bank_hi_d = bank_hi_q;
    mode_d    = mode_q;
    if (do_commit) begin
      case (wr_region)
        REGION_RAM_EN:  ram_en_d  = (wr_data[3:0] == RAM_EN_KEY);
        REGION_BANK_LO: bank_lo_d = fix_bank_lo(wr_data[4:0]);
        REGION_BANK_HI: bank_hi_d = wr_data[1:0];
        REGION_MODE:    mode_d    = wr_data[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en_q  <= 1'b0;
      bank_lo_q <= 5'd1;
      bank_hi_q <= 2'd0;
      mode_q    <= 1'b0;
    end else begin
      ram_en_q  <= ram_en_d;
      bank_lo_q <= bank_lo_d;
      bank_hi_q <= bank_hi_d;
      mode_q    <= mode_d;
    end
  end

  // ROM translation; upper bank bits fall off the top when the image is small.
  logic [6:0]  rom_bank_sel;
  logic [20:0] rom_full;

  always_comb begin
    if (bus.bus_A_s[14])  rom_bank_sel = {bank_hi_q, bank_lo_q};
    else if (mode_q)      rom_bank_sel = {bank_hi_q, 5'b0};
    else                  rom_bank_sel = 7'd0;
  end

  assign rom_full     = {rom_bank_sel, bus.bus_A_s[13:0]};
  assign bus.rom_addr = rom_full[ROM_ADDR_W-1:0];

  // During the write pulse the RAM sees the address latched with the data.
  logic [12:0] ram_a_lo;
  logic [14:0] ram_full;

  assign ram_a_lo     = commit ? wr_addr[12:0] : bus.bus_A_s[12:0];
  assign ram_full     = {(mode_q ? bank_hi_q : 2'b00), ram_a_lo};
  assign bus.ram_addr = ram_full[RAM_ADDR_W-1:0];
  assign bus.ram_we   = do_commit && (wr_region == REGION_EXT_RAM) && ram_en_q;
  assign bus.ram_wd   = wr_data;

  always_comb begin
    if (!bus.bus_A_s[15])
      bus.rd_sel = RD_ROM;
    else if ((bus.bus_A_s[15:13] == REGION_EXT_RAM) && ram_en_q)
      bus.rd_sel = RD_RAM;
    else
      bus.rd_sel = RD_OPEN;
  end

  assign bus.rom_bank = bank_lo_q;

endmodule
